// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT input buffer slice.
package fft_pkg;

  localparam int WIDTH      = 13;
  localparam int DATA_WIDTH = 16;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef sample_t lane_vec_t [0:DATA_WIDTH-1];

  // A bank is either collecting samples or holding a complete block.
  typedef enum logic {
    BANK_FILLING = 1'b0,
    BANK_FULL    = 1'b1
  } bank_st_e;

  // Reverse the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    logic [31:0] sh;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        sh = idx >> i;
        r  = {r[30:0], sh[0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_in_buf_if.sv
// Sample-in / block-out handshake bundle for fft_in_buf, including flush.
interface fft_in_buf_if #(
  parameter int WIDTH      = 13,
  parameter int DATA_WIDTH = 16
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;
  logic                    dout_valid;
  logic                    dout_ready;
  logic signed [WIDTH-1:0] dout_re [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] dout_im [0:DATA_WIDTH-1];

  // The buffer itself.
  modport slave (
    input  flush, in_valid, in_re, in_im, dout_ready,
    output in_ready, dout_valid, dout_re, dout_im
  );

  // Upstream sample source plus downstream add_sub_1_2 consumer.
  modport master (
    output flush, in_valid, in_re, in_im, dout_ready,
    input  in_ready, dout_valid, dout_re, dout_im
  );
endinterface

// File: rtl/fft_in_bank.sv
// One DATA_WIDTH-lane complex register bank; one lane written per enabled cycle.
module fft_in_bank #(
  parameter int WIDTH      = 13,
  parameter int DATA_WIDTH = 16,
  localparam int AW        = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    we,
  input  logic [AW-1:0]           idx,
  input  logic signed [WIDTH-1:0] wr_re,
  input  logic signed [WIDTH-1:0] wr_im,
  output logic signed [WIDTH-1:0] rd_re [0:DATA_WIDTH-1],
  output logic signed [WIDTH-1:0] rd_im [0:DATA_WIDTH-1]
);

  // Lane storage; reset clears every lane so an idle output reads zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        rd_re[i] <= '0;
        rd_im[i] <= '0;
      end
    end else if (we) begin
      rd_re[idx] <= wr_re;
      rd_im[idx] <= wr_im;
    end
  end

endmodule

// File: rtl/fft_in_buf.sv
// Serial-to-parallel ping-pong input buffer feeding add_sub_1_2.
// Build option: define FFT_IN_BUF_BITREV_EN to write sample n of a block
// into lane bitrev(n) (DIT ordering); otherwise lane n (DIF ordering).
//
// Per-bank state:
//   state        | meaning
//   BANK_FILLING | bank is empty or collecting samples (only the wr_bank one fills)
//   BANK_FULL    | bank holds a complete block awaiting drain
module fft_in_buf #(
  parameter int WIDTH      = fft_pkg::WIDTH,
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH
) (
  input logic          clk,
  input logic          rstn,
  fft_in_buf_if.slave  bus
);
  import fft_pkg::*;

  localparam int AW = $clog2(DATA_WIDTH);

  bank_st_e    bank_st     [0:1];
  bank_st_e    bank_st_nxt [0:1];
  logic        wr_bank;
  logic        rd_bank;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] wr_lane;
  logic        accept;
  logic        drain;
  logic        fill_done;

  logic signed [WIDTH-1:0] b0_re [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] b0_im [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] b1_re [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] b1_im [0:DATA_WIDTH-1];

  // Handshakes: readiness comes only from registered state, so a drain frees
  // the write bank for the following cycle, never the same one.
  always_comb begin
    bus.in_ready   = (bank_st[wr_bank] == BANK_FILLING) & ~bus.flush;
    bus.dout_valid = (bank_st[rd_bank] == BANK_FULL) & ~bus.flush;
    accept         = bus.in_valid & bus.in_ready;
    drain          = bus.dout_valid & bus.dout_ready;
    fill_done      = accept & (wr_idx == AW'(DATA_WIDTH - 1));
  end

  // Lane mapping for the incoming sample.
  always_comb begin
`ifdef FFT_IN_BUF_BITREV_EN
    wr_lane = AW'(bitrev(32'(wr_idx), AW));
`else
    wr_lane = wr_idx;
`endif
  end

  // Bank state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_st[0] <= BANK_FILLING;
      bank_st[1] <= BANK_FILLING;
    end else begin
      bank_st[0] <= bank_st_nxt[0];
      bank_st[1] <= bank_st_nxt[1];
    end
  end

  // Bank next state; fill and drain always target different banks, so both apply.
  always_comb begin
    bank_st_nxt[0] = bank_st[0];
    bank_st_nxt[1] = bank_st[1];
    if (bus.flush) begin
      bank_st_nxt[0] = BANK_FILLING;
      bank_st_nxt[1] = BANK_FILLING;
    end else begin
      if (fill_done) bank_st_nxt[wr_bank] = BANK_FULL;
      if (drain)     bank_st_nxt[rd_bank] = BANK_FILLING;
    end
  end

  // Write/read pointers and the write index within the filling bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (bus.flush) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (accept)    wr_idx  <= wr_idx + AW'(1);
      if (fill_done) wr_bank <= ~wr_bank;
      if (drain)     rd_bank <= ~rd_bank;
    end
  end

  fft_in_bank #(.WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank0 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (accept & ~wr_bank),
    .idx   (wr_lane),
    .wr_re (bus.in_re),
    .wr_im (bus.in_im),
    .rd_re (b0_re),
    .rd_im (b0_im)
  );

  fft_in_bank #(.WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank1 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (accept & wr_bank),
    .idx   (wr_lane),
    .wr_re (bus.in_re),
    .wr_im (bus.in_im),
    .rd_re (b1_re),
    .rd_im (b1_im)
  );

  // Present the read bank directly from its registers.
  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      bus.dout_re[i] = rd_bank ? b1_re[i] : b0_re[i];
      bus.dout_im[i] = rd_bank ? b1_im[i] : b0_im[i];
    end
  end

endmodule
